frame_mem_arbiter: RTL

- Shares the single-port frame memory between two requesters:
  - the HDMI/VGA scan-out reader (19-bit address, 12-bit RGB444 data);
  - the camera pixel writer.
- Reads come at pixel rate during active video and always win.
- Writes are buffered in a small FIFO and drain into memory on cycles with no read request (blanking and gaps).
- Sits between the camera capture path, the display timing generator and the frame RAM.

---
 rtl/frame_mem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/frame_mem_arbiter.sv
// Frame memory arbiter. The display reader always wins the memory port, and camera writes
// wait in a small FIFO that drains into memory on cycles with no read request.
module frame_mem_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 12,
  parameter int FIFO_AW = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Rd_Req,
  input  logic [ADDR_W-1:0]   Rd_Add,
  output logic [DATA_W-1:0]   Rd_Data,
  output logic                Rd_Valid,
  input  logic                Wr_Req,
  input  logic [ADDR_W-1:0]   Wr_Add,
  input  logic [DATA_W-1:0]   Wr_Data,
  output logic                Wr_Full,
  output logic                Wr_Overflow,
  input  logic                Ovf_Clr,
  output logic [FIFO_AW:0]    Fifo_Level,
  output logic                Mem_En,
  output logic                Mem_We,
  output logic [ADDR_W-1:0]   Mem_Add,
  output logic [DATA_W-1:0]   Mem_WData,
  input  logic [DATA_W-1:0]   Mem_RData
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [FIFO_AW:0] C_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  logic [ENT_W-1:0]  r_fifo [DEPTH];
  logic [FIFO_AW:0]  r_wrPtr;
  logic [FIFO_AW:0]  r_rdPtr;
  logic              r_full;
  logic              r_ovf;
  logic              r_memEn;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAdd;
  logic [DATA_W-1:0] r_memWData;
  logic [RD_LAT:0]   r_rdPipe;

  logic              w_push;
  logic              w_pop;
  logic [FIFO_AW:0]  w_level;
  logic [FIFO_AW:0]  w_levelNext;
  logic [ENT_W-1:0]  w_head;

  // Pop is decided on start-of-cycle occupancy, so a word pushed this cycle cannot bypass.
  assign w_level     = r_wrPtr - r_rdPtr;
  assign w_push      = Wr_Req & ~r_full;
  assign w_pop       = ~Rd_Req & (w_level != '0);
  assign w_levelNext = w_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
  assign w_head      = r_fifo[r_rdPtr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr[FIFO_AW-1:0]] <= {Wr_Add, Wr_Data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_full <= (w_levelNext == C_DEPTH);
      // A drop in the same cycle as a clear keeps the flag set.
      if (Wr_Req && r_full) r_ovf <= 1'b1;
      else if (Ovf_Clr)     r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_memEn    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAdd   <= '0;
      r_memWData <= '0;
      r_rdPipe   <= '0;
    end else begin
      r_rdPipe <= {r_rdPipe[RD_LAT-1:0], Rd_Req};
      if (Rd_Req) begin
        r_memEn  <= 1'b1;
        r_memWe  <= 1'b0;
        r_memAdd <= Rd_Add;
      end else if (w_pop) begin
        r_memEn    <= 1'b1;
        r_memWe    <= 1'b1;
        r_memAdd   <= w_head[ENT_W-1:DATA_W];
        r_memWData <= w_head[DATA_W-1:0];
      end else begin
        r_memEn <= 1'b0;
        r_memWe <= 1'b0;
      end
    end
  end

  assign Rd_Valid    = r_rdPipe[RD_LAT];
  assign Rd_Data     = r_rdPipe[RD_LAT] ? Mem_RData : '0;
  assign Wr_Full     = r_full;
  assign Wr_Overflow = r_ovf;
  assign Fifo_Level  = w_level;
  assign Mem_En      = r_memEn;
  assign Mem_We      = r_memWe;
  assign Mem_Add     = r_memAdd;
  assign Mem_WData   = r_memWData;

endmodule
